// File: rtl/csr_seq_pkg.sv
// Shared definitions for the CSR row sequencer: state encoding and address-width defaults.
package csr_seq_pkg;

  localparam int unsigned ROW_AW_DEFAULT = 10;
  localparam int unsigned NZ_AW_DEFAULT  = 14;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RD0   = 3'd1,
    WAIT0 = 3'd2,
    RDN   = 3'd3,
    WAITN = 3'd4,
    EMIT  = 3'd5,
    FIN   = 3'd6
  } state_e;

endpackage

// File: rtl/csr_row_sequencer.sv
// Walks a CSR row-pointer array and issues one nonzero-address beat per element
// (or one empty beat per empty row) to a downstream MAC, row by row.
module csr_row_sequencer
  import csr_seq_pkg::*;
#(
  parameter int unsigned ROW_AW = ROW_AW_DEFAULT,
  parameter int unsigned NZ_AW  = NZ_AW_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [ROW_AW-1:0] num_rows,
  output logic [ROW_AW-1:0] rowptr_addr,
  input  logic [31:0]       rowptr_data,
  output logic              nz_valid,
  input  logic              nz_ready,
  output logic [NZ_AW-1:0]  nz_addr,
  output logic [ROW_AW-1:0] row_idx,
  output logic              row_last,
  output logic              row_empty,
  output logic              busy,
  output logic              done,
  output logic              ptr_err
);

  state_e            state_q, state_d;
  logic [ROW_AW-1:0] r_q, r_d;
  logic [ROW_AW-1:0] num_rows_q, num_rows_d;
  logic [NZ_AW-1:0]  ptr_lo_q, ptr_lo_d;
  logic [NZ_AW-1:0]  ptr_hi_q, ptr_hi_d;
  logic [NZ_AW-1:0]  cur_q, cur_d;
  logic              ptr_err_q, ptr_err_d;

  logic [NZ_AW-1:0]  ptr_rd;
  logic              emit;
  logic              empty_c;
  logic              last_c;
  logic              unused_rowptr;

  assign ptr_rd        = rowptr_data[NZ_AW-1:0];
  assign unused_rowptr = ^rowptr_data;

  // A decreasing pointer (hi < lo) is reported via ptr_err and emitted as an empty row.
  assign emit    = (state_q == EMIT);
  assign empty_c = !(ptr_hi_q > ptr_lo_q);
  assign last_c  = empty_c || ((cur_q + NZ_AW'(1)) == ptr_hi_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      r_q        <= '0;
      num_rows_q <= '0;
      ptr_lo_q   <= '0;
      ptr_hi_q   <= '0;
      cur_q      <= '0;
      ptr_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      r_q        <= r_d;
      num_rows_q <= num_rows_d;
      ptr_lo_q   <= ptr_lo_d;
      ptr_hi_q   <= ptr_hi_d;
      cur_q      <= cur_d;
      ptr_err_q  <= ptr_err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    r_d        = r_q;
    num_rows_d = num_rows_q;
    ptr_lo_d   = ptr_lo_q;
    ptr_hi_d   = ptr_hi_q;
    cur_d      = cur_q;
    ptr_err_d  = ptr_err_q;

    if (abort && (state_q != IDLE)) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            num_rows_d = num_rows;
            r_d        = '0;
            ptr_err_d  = 1'b0;
            state_d    = (num_rows == '0) ? FIN : RD0;
          end
        end
        RD0:   state_d = WAIT0;
        WAIT0: begin
          ptr_lo_d = ptr_rd;
          state_d  = RDN;
        end
        RDN:   state_d = WAITN;
        WAITN: begin
          ptr_hi_d = ptr_rd;
          cur_d    = ptr_lo_q;
          if (ptr_rd < ptr_lo_q) ptr_err_d = 1'b1;
          state_d  = EMIT;
        end
        EMIT: begin
          if (nz_ready) begin
            if (last_c) begin
              ptr_lo_d = ptr_hi_q;
              r_d      = r_q + ROW_AW'(1);
              state_d  = (r_q == (num_rows_q - ROW_AW'(1))) ? FIN : RDN;
            end else begin
              cur_d = cur_q + NZ_AW'(1);
            end
          end
        end
        FIN:     state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    rowptr_addr = (state_q == RDN) ? (r_q + ROW_AW'(1)) : '0;
    nz_valid    = emit;
    nz_addr     = emit ? cur_q : '0;
    row_idx     = emit ? r_q : '0;
    row_last    = emit && last_c;
    row_empty   = emit && empty_c;
    busy        = (state_q != IDLE);
    done        = (state_q == FIN);
    ptr_err     = ptr_err_q;
  end

endmodule

// File: tb/tb_csr_row_sequencer.sv
// Directed self-checking bench for csr_row_sequencer with a 1-cycle-latency row-pointer RAM model.
module tb_csr_row_sequencer;

  localparam int ROW_AW = 10;
  localparam int NZ_AW  = 14;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic              abort = 1'b0;
  logic [ROW_AW-1:0] num_rows = '0;
  logic [ROW_AW-1:0] rowptr_addr;
  logic [31:0]       rowptr_data = '0;
  logic              nz_valid;
  logic              nz_ready = 1'b1;
  logic [NZ_AW-1:0]  nz_addr;
  logic [ROW_AW-1:0] row_idx;
  logic              row_last;
  logic              row_empty;
  logic              busy;
  logic              done;
  logic              ptr_err;

  int checks = 0;
  int failures = 0;

  logic [31:0]       mem [16];
  logic [NZ_AW-1:0]  ea [8];
  logic [ROW_AW-1:0] er [8];
  logic              el [8];
  logic              ee [8];

  csr_row_sequencer #(.ROW_AW(ROW_AW), .NZ_AW(NZ_AW)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .num_rows(num_rows),
    .rowptr_addr(rowptr_addr), .rowptr_data(rowptr_data),
    .nz_valid(nz_valid), .nz_ready(nz_ready), .nz_addr(nz_addr), .row_idx(row_idx),
    .row_last(row_last), .row_empty(row_empty), .busy(busy), .done(done), .ptr_err(ptr_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) rowptr_data <= mem[rowptr_addr[3:0]];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_beat(input int i, input int a, input int r, input logic l, input logic e);
    ea[i] = NZ_AW'(a);
    er[i] = ROW_AW'(r);
    el[i] = l;
    ee[i] = e;
  endtask

  task automatic start_pass(input int n);
    @(negedge clk);
    start = 1'b1;
    num_rows = ROW_AW'(n);
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Runs one full pass and checks the beat stream, stall stability and done timing.
  task automatic run_pass(input int n, input int n_exp, input bit toggle, input int exp_first);
    int k = 0;
    int first_cyc = 0;
    int last_cyc = -10;
    int done_cyc = 0;
    bit stalled = 1'b0;
    logic rdy;
    logic [31:0] obs, prev_obs;
    logic [NZ_AW-1:0] am, em;
    prev_obs = '0;
    start_pass(n);
    for (int cyc = 1; cyc <= 200; cyc++) begin
      @(negedge clk);
      obs = 32'({nz_valid, nz_addr, row_idx, row_last, row_empty});
      if (stalled) chk("stall_hold", obs, prev_obs);
      if (nz_valid && first_cyc == 0) first_cyc = cyc;
      if (done) begin
        done_cyc = cyc;
        break;
      end
      rdy = toggle ? logic'(cyc % 2 == 1) : 1'b1;
      nz_ready = rdy;
      if (nz_valid && rdy) begin
        if (k < n_exp) begin
          am = ee[k] ? '0 : nz_addr;
          em = ee[k] ? '0 : ea[k];
          chk($sformatf("beat%0d", k), 32'({am, row_idx, row_last, row_empty}),
              32'({em, er[k], el[k], ee[k]}));
        end
        k++;
        last_cyc = cyc;
      end
      stalled = nz_valid && !rdy;
      prev_obs = obs;
    end
    nz_ready = 1'b1;
    chk("beat_count", 32'(k), 32'(n_exp));
    chk("done_after_last", 32'(done_cyc), 32'(last_cyc + 1));
    if (exp_first != 0) chk("first_valid_cyc", 32'(first_cyc), 32'(exp_first));
    @(negedge clk);
    chk("idle_after_done", 32'({busy, done, nz_valid}), 32'(0));
  endtask

  initial begin
    bit seen;
    for (int i = 0; i < 16; i++) mem[i] = '0;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    chk("reset_outputs", 32'({rowptr_addr, nz_addr, nz_valid, row_last, row_empty}), 32'(0));
    chk("reset_status", 32'({row_idx, busy, done, ptr_err}), 32'(0));
    rst = 1'b0;

    // Basic pass, ready always high
    mem[0] = 0; mem[1] = 2; mem[2] = 2; mem[3] = 5;
    set_beat(0, 0, 0, 0, 0); set_beat(1, 1, 0, 1, 0);
    set_beat(2, 0, 1, 1, 1);
    set_beat(3, 2, 2, 0, 0); set_beat(4, 3, 2, 0, 0); set_beat(5, 4, 2, 1, 0);
    run_pass(3, 6, 1'b0, 5);
    chk("ptr_err_clean", 32'(ptr_err), 32'(0));

    // Same pass with ready toggling
    run_pass(3, 6, 1'b1, 5);

    // Zero rows
    start_pass(0);
    @(negedge clk);
    chk("zero_rows_t1", 32'({done, busy, nz_valid}), 32'(3'b110));
    @(negedge clk);
    chk("zero_rows_t2", 32'({done, busy, nz_valid}), 32'(0));

    // Decreasing pointer
    mem[0] = 0; mem[1] = 4; mem[2] = 3;
    set_beat(0, 0, 0, 0, 0); set_beat(1, 1, 0, 0, 0);
    set_beat(2, 2, 0, 0, 0); set_beat(3, 3, 0, 1, 0);
    set_beat(4, 0, 1, 1, 1);
    run_pass(2, 5, 1'b0, 5);
    chk("ptr_err_set", 32'(ptr_err), 32'(1));

    // Abort during the second beat of a 4-beat row; new start clears ptr_err
    mem[0] = 0; mem[1] = 4; mem[2] = 4;
    start_pass(2);
    @(negedge clk);
    chk("ptr_err_cleared", 32'(ptr_err), 32'(0));
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (nz_valid) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk("abort_first_beat_valid", 32'(seen), 32'(1));
    @(negedge clk);
    chk("abort_second_beat_addr", 32'({nz_valid, nz_addr}), 32'({1'b1, NZ_AW'(1)}));
    abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    @(negedge clk);
    chk("abort_idle", 32'({busy, nz_valid, done}), 32'(0));
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (done || busy) seen = 1'b1;
      @(negedge clk);
    end
    chk("abort_no_done", 32'(seen), 32'(0));
    set_beat(0, 0, 0, 0, 0); set_beat(1, 1, 0, 0, 0);
    set_beat(2, 2, 0, 0, 0); set_beat(3, 3, 0, 1, 0);
    set_beat(4, 4, 1, 1, 1);
    run_pass(2, 5, 1'b0, 5);

    // Asynchronous reset while emitting
    start_pass(2);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (nz_valid) begin
        seen = 1'b1;
        break;
      end
    end
    chk("rst_reach_emit", 32'(seen), 32'(1));
    #2 rst = 1'b1;
    #1;
    chk("rst_async_outputs", 32'({rowptr_addr, nz_addr, nz_valid, row_last, row_empty}), 32'(0));
    chk("rst_async_status", 32'({row_idx, busy, done, ptr_err}), 32'(0));
    @(negedge clk);
    rst = 1'b0;
    start = 1'b1;
    num_rows = ROW_AW'(2);
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    chk("start_after_rst", 32'({busy, done}), 32'(2'b10));
    abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    @(negedge clk);
    chk("final_abort_idle", 32'({busy, done, nz_valid}), 32'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
